// File: rtl/apb_ahb_pkg.sv
// Shared AHB-Lite encodings and bridge state type for the APB3-to-AHB bridge.
package apb_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/apb3_to_ahb_bridge.sv
// APB3 slave that replays each APB transfer as one single-word AHB-Lite NONSEQ
// transfer, stalling PREADY until the AHB data phase has completed.
module apb3_to_ahb_bridge
  import apb_ahb_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL        = 4'b0011,
  parameter bit         ERR_ON_UNALIGNED = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: an APB transfer is taken only from a setup phase seen in IDLE
  // (PSEL=1, PENABLE=0); PREADY is high for exactly the one DONE cycle. On AHB
  // an address or data phase advances only on a cycle where HREADY=1.

  state_t      state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] prdata_q, prdata_d;
  logic        err_q, err_d;

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state_q  <= IDLE;
      haddr_q  <= '0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
      wdata_q  <= '0;
      prdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
      wdata_q  <= wdata_d;
      prdata_q <= prdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;
    wdata_d  = wdata_q;
    prdata_d = prdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          wdata_d = PWDATA;
          if (ERR_ON_UNALIGNED && (PADDR[1:0] != 2'b00)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            haddr_d  = PADDR;
            hwrite_d = PWRITE;
            htrans_d = HTRANS_NONSEQ;
            state_d  = ADDR;
          end
        end
      end
      ADDR: begin
        if (HREADY) begin
          htrans_d = HTRANS_IDLE;
          hwdata_d = wdata_q;
          state_d  = DATA;
        end
      end
      DATA: begin
        // Waiting cycles, including the first cycle of a two-cycle ERROR, just hold.
        if (HREADY) begin
          if (!hwrite_q) prdata_d = HRDATA;
          err_d   = (HRESP == HRESP_ERROR);
          state_d = DONE;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign PREADY      = (state_q == DONE);
  assign PSLVERR     = (state_q == DONE) && err_q;
  assign PRDATA      = prdata_q;
  assign HADDR       = haddr_q;
  assign HTRANS      = htrans_q;
  assign HWRITE      = hwrite_q;
  assign HWDATA      = hwdata_q;
  assign HSIZE       = HSIZE_WORD;
  assign HBURST      = HBURST_SINGLE;
  assign HPROT       = HPROT_VAL;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb3_to_ahb_bridge.sv
// Self-checking bench: APB master tasks, a scripted AHB-Lite slave, and
// scoreboard queues for AHB address phases and APB completions.
module tb_apb3_to_ahb_bridge;
  import apb_ahb_pkg::*;

  logic        HCLK, HRESETN;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic        HWRITE, HREADY;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  dbg_state;

  apb3_to_ahb_bridge #(.HPROT_VAL(4'b0011), .ERR_ON_UNALIGNED(1'b1)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [64:0] ahb_exp_q[$];   // {haddr, hwrite, hwdata}
  logic [32:0] apb_exp_q[$];   // {pslverr, prdata}
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- AHB slave model ----------------
  int          cfg_waits = 0;
  logic        cfg_err   = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;
  int          nonseq_cnt = 0;
  int          prev_ns_cyc = 0;
  int          last_ns_cyc = 0;

  initial begin
    logic [64:0] e;
    logic        dp_w;
    logic [31:0] dp_wd;
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    HRDATA = 32'h0;
    forever begin
      @(negedge HCLK);
      if (HRESETN && HTRANS == HTRANS_NONSEQ && HREADY) begin
        nonseq_cnt++;
        prev_ns_cyc = last_ns_cyc;
        last_ns_cyc = cyc;
        dp_w  = 1'b0;
        dp_wd = 32'h0;
        if (ahb_exp_q.size() == 0) begin
          chk("ahb_unexpected_nonseq", 64'(HADDR), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = ahb_exp_q.pop_front();
          chk("haddr", 64'(HADDR), 64'(e[64:33]));
          chk("hwrite", 64'(HWRITE), 64'(e[32]));
          chk("hsize", 64'(HSIZE), 64'(3'b010));
          dp_w  = e[32];
          dp_wd = e[31:0];
        end
        @(posedge HCLK); #1;
        if (cfg_err) begin
          HRESP  = HRESP_ERROR;
          HREADY = 1'b0;
          @(posedge HCLK); #1;
          HREADY = 1'b1;
          HRDATA = cfg_rdata;
        end else begin
          repeat (cfg_waits) begin
            HREADY = 1'b0;
            @(posedge HCLK); #1;
          end
          HREADY = 1'b1;
          HRDATA = cfg_rdata;
        end
        @(negedge HCLK);
        if (dp_w) chk("hwdata", 64'(HWDATA), 64'(dp_wd));
        @(posedge HCLK); #1;
        HRESP  = HRESP_OKAY;
        HRDATA = 32'h0;
      end
    end
  end

  // ---------------- APB driver tasks ----------------
  task automatic apb_idle(input int n);
    @(posedge HCLK); #1;
    PSEL = 1'b0;
    PENABLE = 1'b0;
    repeat (n) @(posedge HCLK);
  endtask

  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input int waits, input logic err, input logic [31:0] rdata,
                          input int exp_lat);
    logic        unal;
    logic        e_err;
    logic [31:0] e_rd;
    logic [32:0] e;
    int          n;
    unal      = (addr[1:0] != 2'b00);
    cfg_waits = waits;
    cfg_err   = err;
    cfg_rdata = rdata;
    if (!unal) ahb_exp_q.push_back({addr, wr, wdata});
    e_err = unal ? 1'b1 : err;
    e_rd  = (unal || wr) ? last_rd : rdata;
    if (!unal && !wr) last_rd = rdata;
    apb_exp_q.push_back({e_err, e_rd});
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
    n = 0;
    do begin
      @(posedge HCLK); #1;
      PENABLE = 1'b1;
      n++;
    end while (!PREADY && n < 40);
    chk("latency", 64'(n), 64'(exp_lat));
    e = apb_exp_q.pop_front();
    chk("pslverr", 64'(PSLVERR), 64'(e[32]));
    chk("prdata", 64'(PRDATA), 64'(e[31:0]));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt0;
    logic [31:0] a, d;
    logic        w;
    int          ws;
    HRESETN = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PADDR = 32'h0; PWRITE = 1'b0; PWDATA = 32'h0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
    chk("rst_haddr", 64'(HADDR), 64'h0);
    chk("rst_hwrite", 64'(HWRITE), 64'h0);
    chk("rst_hwdata", 64'(HWDATA), 64'h0);
    chk("rst_prdata", 64'(PRDATA), 64'h0);
    chk("rst_pready", 64'(PREADY), 64'h0);
    chk("rst_pslverr", 64'(PSLVERR), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    chk("hburst", 64'(HBURST), 64'(3'b000));
    chk("hprot", 64'(HPROT), 64'(4'b0011));
    HRESETN = 1'b1;
    apb_idle(2);

    // Zero-wait write, then read with two wait states.
    apb_xfer(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 3);
    chk("pready_one_cycle", 64'(PREADY), 64'h1);
    apb_idle(2);
    chk("pready_low_after", 64'(PREADY), 64'h0);
    apb_xfer(32'h0000_1008, 1'b0, 32'h0, 2, 1'b0, 32'h1234_5678, 5);
    apb_idle(2);

    // Two-cycle ERROR, then a clean transfer immediately after.
    apb_xfer(32'h2000_0000, 1'b0, 32'h0, 0, 1'b1, 32'hBAD0_0BAD, 4);
    apb_xfer(32'h2000_0004, 1'b0, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 3);
    #6;
    chk("pslverr_one_cycle", 64'(PSLVERR), 64'h0);
    apb_idle(2);

    // Unaligned reject: no AHB traffic at all.
    cnt0 = nonseq_cnt;
    apb_xfer(32'h0000_0002, 1'b1, 32'h0BAD_CAFE, 0, 1'b0, 32'h0, 1);
    apb_idle(4);
    chk("unaligned_no_ahb", 64'(nonseq_cnt), 64'(cnt0));

    // Back-to-back: setup in the cycle after PREADY.
    apb_xfer(32'h0000_0010, 1'b1, 32'h55AA_55AA, 0, 1'b0, 32'h0, 3);
    apb_xfer(32'h0000_0014, 1'b0, 32'h0, 0, 1'b0, 32'h0F0F_1234, 3);
    chk("b2b_nonseq_spacing", 64'(last_ns_cyc - prev_ns_cyc), 64'd4);
    apb_idle(2);

    // Random aligned transfers with random wait states.
    for (int i = 0; i < 6; i++) begin
      a  = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
      w  = 1'($urandom_range(0, 1));
      d  = $urandom();
      ws = $urandom_range(0, 3);
      apb_xfer(a, w, d, ws, 1'b0, $urandom(), 3 + ws);
      if ($urandom_range(0, 1) == 1) apb_idle($urandom_range(0, 2));
    end
    apb_xfer(32'h0000_0020, 1'b0, 32'h0, 0, 1'b0, 32'hA5A5_0001, 3);
    apb_idle(1);

    // Reset during the data phase of a read.
    cfg_waits = 6; cfg_err = 1'b0; cfg_rdata = 32'h7777_7777;
    ahb_exp_q.push_back({32'h3000_0000, 1'b0, 32'h0});
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h3000_0000; PWRITE = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    chk("mid_state_data", 64'(dbg_state), 64'(DATA));
    HRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    chk("mid_rst_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
    chk("mid_rst_pready", 64'(PREADY), 64'h0);
    chk("mid_rst_prdata", 64'(PRDATA), 64'h0);
    chk("mid_rst_hwdata", 64'(HWDATA), 64'h0);
    chk("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    HRESETN = 1'b1;
    last_rd = 32'h0;
    repeat (10) @(posedge HCLK);

    // Fresh transfers after release.
    apb_xfer(32'h0000_0040, 1'b1, 32'h1357_9BDF, 1, 1'b0, 32'h0, 4);
    apb_xfer(32'h0000_0044, 1'b0, 32'h0, 0, 1'b0, 32'h2468_ACE0, 3);
    apb_idle(3);
    chk("ahb_q_drained", 64'(ahb_exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb3_to_ahb_bridge.md
Name: apb3_to_ahb_bridge

Overview:
- APB3 slave / AHB-Lite master bridge, single clock domain.
- Accepts one APB3 transfer at a time from an APB3 initiator and replays it as a single-word AHB-Lite NONSEQ transfer.
- Holds PREADY low until the AHB data phase completes, then returns PRDATA/PSLVERR.
- Complements the existing AHB-to-APB3 path: lets APB-side masters reach the AHB fabric (SRAM, peripherals).

Parameters:
- HPROT_VAL, 4'b0011, constant driven on HPROT (non-cacheable, non-bufferable, privileged data).
- ERR_ON_UNALIGNED, 1, when 1 a PADDR[1:0]!=0 transfer is rejected with PSLVERR and no AHB transfer; when 0 the address is passed through unchanged.

Ports:
- HCLK  in  1  clock for both interfaces
- HRESETN  in  1  reset, synchronous, active-low
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PADDR  in  32  APB address
- PWRITE  in  1  APB direction (1 = write)
- PWDATA  in  32  APB write data
- PRDATA  out  32  APB read data
- PREADY  out  1  APB ready
- PSLVERR  out  1  APB error
- HADDR  out  32  AHB address
- HTRANS  out  2  AHB transfer type
- HWRITE  out  1  AHB direction
- HSIZE  out  3  constant 3'b010 (word)
- HBURST  out  3  constant 3'b000 (SINGLE)
- HPROT  out  4  constant HPROT_VAL
- HWDATA  out  32  AHB write data
- HRDATA  in  32  AHB read data
- HREADY  in  1  AHB ready (bus-level)
- HRESP  in  2  AHB response (00 OKAY, 01 ERROR)

Behaviour:
- Interfaces: HCLK clocks both sides. HRESETN is synchronous, active-low: all state is sampled and cleared on the rising edge of HCLK only.
- Reset values:
  - state IDLE; HADDR 0; HTRANS 2'b00; HWRITE 0; HWDATA 0; PRDATA 0.
  - PREADY 0; PSLVERR 0; internal wdata/err registers 0.
- State IDLE:
  - On setup phase (PSEL=1, PENABLE=0), capture PADDR, PWRITE, PWDATA.
  - If ERR_ON_UNALIGNED and PADDR[1:0]!=0: err<=1, go to DONE.
  - Otherwise: HADDR<=PADDR, HWRITE<=PWRITE, HTRANS<=NONSEQ, go to ADDR.
- State ADDR: NONSEQ is presented on the bus.
  - HREADY=1: HTRANS<=IDLE; HWDATA<=captured wdata (valid throughout the data phase); go to DATA.
  - HREADY=0: hold all address-phase outputs.
- State DATA:
  - HREADY=1: PRDATA<=HRDATA (reads only; writes leave PRDATA unchanged); err<=(HRESP==ERROR); go to DONE.
  - HREADY=0 with HRESP=ERROR (first error cycle): wait.
- State DONE:
  - PREADY=1 and PSLVERR=err, both decoded combinationally from state, so each is high for exactly one cycle.
  - Next state IDLE; err<=0.
- PREADY is 0 in every state except DONE. PSLVERR is 0 outside DONE.
- Latency, zero-wait AHB slave:
  - Setup at T0; NONSEQ visible at T1; data phase at T2; PREADY=1 at T3.
  - Each AHB wait state adds 1 cycle.
  - Unaligned reject: PREADY=1 at T1.
- Back-to-back: a setup phase in the cycle immediately after DONE is accepted (IDLE samples it).
- PSEL dropped before DONE (protocol violation): the AHB transfer still completes (no AHB abort). DONE is visited and returns to IDLE; the result is discarded.
- Reset mid-transfer: the state machine returns to IDLE and HTRANS is IDLE on the next edge. The AHB slave shares HRESETN.
- HWDATA is held after DATA until the next transfer's ADDR->DATA edge.

Decomposition:
- Package apb_ahb_pkg holds:
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10
  - HRESP_OKAY=2'b00, HRESP_ERROR=2'b01
  - HSIZE_WORD=3'b010, HBURST_SINGLE=3'b000
  - 2-bit state type {IDLE, ADDR, DATA, DONE}
- Single module; no sub-module is warranted.

Test Plan:
- Write, zero-wait: APB write 0x0000_1004 / 0xDEAD_BEEF -> HTRANS=NONSEQ at T1 with HADDR 0x0000_1004, HWRITE=1; HWDATA 0xDEAD_BEEF at T2; PREADY=1 at T3, PSLVERR=0.
- Read, 2 HREADY wait states in the data phase, HRDATA=0x1234_5678 -> PREADY=1 at T5, PRDATA=0x1234_5678, PSLVERR=0.
- Error: read 0x2000_0000; slave gives HRESP=ERROR with HREADY=0, then ERROR with HREADY=1 -> PREADY=1 with PSLVERR=1 for one cycle; next transfer completes OKAY.
- Unaligned: PADDR 0x0000_0002 with ERR_ON_UNALIGNED=1 -> HTRANS stays IDLE throughout; PREADY=1 and PSLVERR=1 at T1.
- Back-to-back: write 0x10, then read 0x14 with setup in the cycle after PREADY -> two NONSEQ transfers, 4 cycles apart, correct data on each.
- Reset mid-transfer: HRESETN=0 during DATA -> on the next edge HTRANS=00, PREADY=0, PRDATA=0; a fresh transfer after release completes normally.
